// File: rtl/ext_mem_bridge.sv
`timescale 1ns/1ps
// ext_mem_bridge
//
// Bridges the core's instruction-fetch and load/store request ports onto a
// single narrow synchronous external SRAM. One 32-bit access is issued at a
// time. It is split into NBEATS = 32/EXT_DW beats on the SRAM side, and read
// beats are reassembled into a 32-bit response word. Requests at or above
// MEM_BYTES are answered with an error response and never reach the SRAM.
//
// Parameters
//   EXT_DW     external SRAM data width (8, 16 or 32)
//   MEM_BYTES  populated SRAM size in bytes (power of two)
//
// Compile-time option
//   EXT_MEM_BRIDGE_RR_EN  when defined, simultaneous requests are arbitrated
//                         round-robin. Otherwise the instruction port has
//                         fixed priority.
//
// Ports
//   clk, rst_ni                 clock (rising edge), async active-low reset
//   instr_req_i/gnt_o/...       instruction read port (req/gnt, rvalid pulse,
//                               err, 32-bit addr and rdata)
//   data_req_i/gnt_o/...        load/store port; adds we, be[3:0], wdata
//   ext_sram_addr_o             byte address of the current beat
//   ext_sram_wdata_o/be_o       write data / byte mask of the current beat
//   ext_sram_read_o/write_o     read / write strobes
//   ext_sram_rdata_i            read data, valid the cycle after read_o
module ext_mem_bridge #(
    parameter int EXT_DW    = 8,
    parameter int MEM_BYTES = 65536
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    // instruction port
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic                  instr_err_o,
    input  logic [31:0]           instr_addr_i,
    output logic [31:0]           instr_rdata_o,
    // data port
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    output logic                  data_rvalid_o,
    output logic                  data_err_o,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_addr_i,
    input  logic [31:0]           data_wdata_i,
    output logic [31:0]           data_rdata_o,
    // external SRAM
    output logic [31:0]           ext_sram_addr_o,
    output logic [EXT_DW-1:0]     ext_sram_wdata_o,
    output logic [EXT_DW/8-1:0]   ext_sram_be_o,
    output logic                  ext_sram_read_o,
    output logic                  ext_sram_write_o,
    input  logic [EXT_DW-1:0]     ext_sram_rdata_i
);

    localparam int NBEATS = 32 / EXT_DW;
    localparam int BEW    = EXT_DW / 8;
    localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(NBEATS - 1);
    localparam logic [31:0]   MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        XFER  = 3'd1,
        DRAIN = 3'd2,
        RESP  = 3'd3,
        ERR   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  beat_q, beat_d;
    logic           port_q, port_d;       // 1 = data port owns the access
    logic [31:0]    addr_q, addr_d;
    logic           we_q, we_d;
    logic [3:0]     be_q, be_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           cap_q, cap_d;         // a read beat's data arrives this cycle
    logic [CW-1:0]  cap_idx_q, cap_idx_d; // which slice that data belongs to
    logic [31:0]    rbuf_q, rbuf_d;
    logic [31:0]    instr_rdata_q, instr_rdata_d;
    logic [31:0]    data_rdata_q, data_rdata_d;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic pick_data;

`ifdef EXT_MEM_BRIDGE_RR_EN
    // 1 = data port was granted most recently. Resetting to "data" lets the
    // instruction port win the first tie.
    logic last_data_q, last_data_d;

    assign pick_data = data_req_i && (!instr_req_i || !last_data_q);

    always_comb begin
        last_data_d = last_data_q;
        if (data_gnt_o) begin
            last_data_d = 1'b1;
        end else if (instr_gnt_o) begin
            last_data_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            last_data_q <= 1'b1;
        end else begin
            last_data_q <= last_data_d;
        end
    end
`else
    assign pick_data = data_req_i && !instr_req_i;
`endif

    assign instr_gnt_o = (state_q == IDLE) && instr_req_i && !pick_data;
    assign data_gnt_o  = (state_q == IDLE) && pick_data;

    logic [31:0] sel_addr;
    assign sel_addr = pick_data ? data_addr_i : instr_addr_i;

    // ------------------------------------------------------------------
    // Per-beat slicing of the captured word and read-data reassembly
    // ------------------------------------------------------------------
    logic [EXT_DW-1:0] wdata_beat [NBEATS];
    logic [BEW-1:0]    be_beat    [NBEATS];

    for (genvar gi = 0; gi < NBEATS; gi++) begin : g_beat
        assign wdata_beat[gi] = wdata_q[gi*EXT_DW +: EXT_DW];
        assign be_beat[gi]    = be_q[gi*BEW +: BEW];
        // SRAM data lags its read strobe by one cycle, so the slice index is
        // remembered from the issuing cycle rather than taken from beat_q.
        assign rbuf_d[gi*EXT_DW +: EXT_DW] = (cap_q && (cap_idx_q == CW'(gi)))
                                             ? ext_sram_rdata_i
                                             : rbuf_q[gi*EXT_DW +: EXT_DW];
    end

    logic [31:0] beat_off;
    assign beat_off = 32'(beat_q) * 32'(BEW);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d          = state_q;
        beat_d           = beat_q;
        port_d           = port_q;
        addr_d           = addr_q;
        we_d             = we_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        cap_d            = 1'b0;
        cap_idx_d        = beat_q;
        instr_rdata_d    = instr_rdata_q;
        data_rdata_d     = data_rdata_q;
        instr_rvalid_o   = 1'b0;
        instr_err_o      = 1'b0;
        data_rvalid_o    = 1'b0;
        data_err_o       = 1'b0;
        ext_sram_addr_o  = 32'h0;
        ext_sram_wdata_o = '0;
        ext_sram_be_o    = '0;
        ext_sram_read_o  = 1'b0;
        ext_sram_write_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_gnt_o || data_gnt_o) begin
                    port_d  = pick_data;
                    addr_d  = {sel_addr[31:2], 2'b00};
                    we_d    = pick_data && data_we_i;
                    be_d    = pick_data ? data_be_i : 4'h0;
                    wdata_d = pick_data ? data_wdata_i : 32'h0;
                    beat_d  = '0;
                    state_d = (sel_addr >= MEM_LIMIT) ? ERR : XFER;
                end
            end

            XFER: begin
                ext_sram_addr_o = addr_q + beat_off;
                if (we_q) begin
                    ext_sram_wdata_o = wdata_beat[beat_q];
                    ext_sram_be_o    = be_beat[beat_q];
                    // An all-zero mask still spends its beat, just unstrobed.
                    ext_sram_write_o = |be_beat[beat_q];
                end else begin
                    ext_sram_read_o = 1'b1;
                    cap_d           = 1'b1;
                end
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    state_d = we_q ? RESP : DRAIN;
                end else begin
                    beat_d = beat_q + CW'(1);
                end
            end

            DRAIN: begin
                // Last read beat is captured into rbuf at the end of this cycle.
                state_d = RESP;
            end

            RESP: begin
                if (port_q) begin
                    data_rvalid_o = 1'b1;
                    if (!we_q) begin
                        data_rdata_d = rbuf_q;
                    end
                end else begin
                    instr_rvalid_o = 1'b1;
                    instr_rdata_d  = rbuf_q;
                end
                state_d = IDLE;
            end

            ERR: begin
                if (port_q) begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = 1'b1;
                    data_rdata_d  = 32'h0;
                end else begin
                    instr_rvalid_o = 1'b1;
                    instr_err_o    = 1'b1;
                    instr_rdata_d  = 32'h0;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // The _d value is presented so new response data is visible alongside
    // rvalid; outside RESP/ERR it equals the held register value.
    assign instr_rdata_o = instr_rdata_d;
    assign data_rdata_o  = data_rdata_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            beat_q        <= '0;
            port_q        <= 1'b0;
            addr_q        <= 32'h0;
            we_q          <= 1'b0;
            be_q          <= 4'h0;
            wdata_q       <= 32'h0;
            cap_q         <= 1'b0;
            cap_idx_q     <= '0;
            rbuf_q        <= 32'h0;
            instr_rdata_q <= 32'h0;
            data_rdata_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            beat_q        <= beat_d;
            port_q        <= port_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            be_q          <= be_d;
            wdata_q       <= wdata_d;
            cap_q         <= cap_d;
            cap_idx_q     <= cap_idx_d;
            rbuf_q        <= rbuf_d;
            instr_rdata_q <= instr_rdata_d;
            data_rdata_q  <= data_rdata_d;
        end
    end

endmodule
